// File: rtl/local_port_ejector.sv
// Receive-side NI for a router local port: FWFT flit FIFO, wormhole head/tail tagging,
// destination check and traffic statistics, with registered buffer_on flow control.
//
// state  | meaning
// S_HEAD | next accepted flit starts a packet
// S_BODY | mid-packet; r_idx is the index of the next accepted flit
module local_port_ejector #(
  parameter int         BUFFER_SIZE      = 8,
  parameter int         FLITS_PER_PACKET = 4,
  parameter logic [1:0] X_CURRENT        = 2'b01,
  parameter logic [1:0] Y_CURRENT        = 2'b01
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [63:0] flit_in,
  input  logic        valid_in,
  output logic        buffer_on_out,
  output logic [63:0] pe_flit,
  output logic        pe_valid,
  output logic        pe_head,
  output logic        pe_tail,
  input  logic        pe_ready,
  output logic [15:0] pkt_count,
  output logic [15:0] flit_count,
  output logic [7:0]  misroute_count,
  output logic        overflow_err
);

  localparam int PTR_W = $clog2(BUFFER_SIZE);
  localparam int CNT_W = PTR_W + 1;
  localparam int IDX_W = (FLITS_PER_PACKET > 1) ? $clog2(FLITS_PER_PACKET) : 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(BUFFER_SIZE);
  localparam logic [CNT_W-1:0] ON_LIMIT = CNT_W'(BUFFER_SIZE - 2);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FLITS_PER_PACKET - 1);

  typedef enum logic {S_HEAD, S_BODY} state_t;

  logic [65:0]      r_mem [BUFFER_SIZE];
  logic [PTR_W-1:0] r_wr_ptr, r_rd_ptr;
  logic [CNT_W-1:0] r_count, w_count_nxt;
  state_t           r_state, w_state_nxt;
  logic [IDX_W-1:0] r_idx, w_idx_nxt;
  logic             w_push, w_pop, w_full;
  logic             w_tag_head, w_tag_tail, w_misroute;

  assign pe_valid = (r_count != '0);
  assign w_full   = (r_count == FULL_CNT);
  assign w_pop    = pe_valid & pe_ready;
  // A full FIFO still accepts a flit when the PE frees a slot in the same cycle.
  assign w_push   = valid_in & (~w_full | w_pop);

  assign pe_flit  = r_mem[r_rd_ptr][63:0];
  assign pe_head  = pe_valid & r_mem[r_rd_ptr][65];
  assign pe_tail  = pe_valid & r_mem[r_rd_ptr][64];

  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_tag_head  = 1'b0;
    w_tag_tail  = 1'b0;
    case (r_state)
      S_HEAD: begin
        w_tag_head = 1'b1;
        if (FLITS_PER_PACKET == 1) begin
          w_tag_tail = 1'b1;
        end else if (w_push) begin
          w_state_nxt = S_BODY;
          w_idx_nxt   = IDX_W'(1);
        end
      end
      S_BODY: begin
        if (r_idx == LAST_IDX) begin
          w_tag_tail = 1'b1;
          if (w_push) begin
            w_state_nxt = S_HEAD;
            w_idx_nxt   = '0;
          end
        end else if (w_push) begin
          w_idx_nxt = r_idx + 1'b1;
        end
      end
      default: w_state_nxt = S_HEAD;
    endcase
  end

  assign w_misroute = w_push & w_tag_head &
                      ((flit_in[63:62] != X_CURRENT) | (flit_in[61:60] != Y_CURRENT));

  always_comb begin
    w_count_nxt = r_count;
    case ({w_push, w_pop})
      2'b10:   w_count_nxt = r_count + 1'b1;
      2'b01:   w_count_nxt = r_count - 1'b1;
      default: w_count_nxt = r_count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= {w_tag_head, w_tag_tail, flit_in};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= S_HEAD;
      r_idx          <= '0;
      r_wr_ptr       <= '0;
      r_rd_ptr       <= '0;
      r_count        <= '0;
      buffer_on_out  <= 1'b0;
      pkt_count      <= '0;
      flit_count     <= '0;
      misroute_count <= '0;
      overflow_err   <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_idx         <= w_idx_nxt;
      r_count       <= w_count_nxt;
      buffer_on_out <= (w_count_nxt <= ON_LIMIT);
      if (w_push) begin
        r_wr_ptr   <= r_wr_ptr + 1'b1;
        flit_count <= flit_count + 1'b1;
      end
      if (w_pop)                    r_rd_ptr       <= r_rd_ptr + 1'b1;
      if (w_push && w_tag_tail)     pkt_count      <= pkt_count + 1'b1;
      if (w_misroute && misroute_count != 8'hFF)
                                    misroute_count <= misroute_count + 1'b1;
      if (valid_in && !w_push)      overflow_err   <= 1'b1;
    end
  end

endmodule

// File: tb/tb_local_port_ejector.sv
// Directed and randomized bench for local_port_ejector; a queue-based model of the
// delivered flit stream and statistics supplies every expected value.
module tb_local_port_ejector;

  localparam int BS  = 8;
  localparam int FPP = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] flit_in;
  logic        valid_in;
  logic        buffer_on_out;
  logic [63:0] pe_flit;
  logic        pe_valid, pe_head, pe_tail, pe_ready;
  logic [15:0] pkt_count, flit_count;
  logic [7:0]  misroute_count;
  logic        overflow_err;

  int checks   = 0;
  int failures = 0;

  // reference model state
  logic [65:0] mq[$];
  int          m_acc;
  logic [15:0] m_pkt, m_flit;
  logic [7:0]  m_mis;
  logic        m_ovf, m_bon;

  local_port_ejector dut (
    .clk(clk), .rst(rst), .flit_in(flit_in), .valid_in(valid_in),
    .buffer_on_out(buffer_on_out), .pe_flit(pe_flit), .pe_valid(pe_valid),
    .pe_head(pe_head), .pe_tail(pe_tail), .pe_ready(pe_ready),
    .pkt_count(pkt_count), .flit_count(flit_count),
    .misroute_count(misroute_count), .overflow_err(overflow_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [65:0] obs, input logic [65:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    chk("pe_valid", 66'(pe_valid), 66'(mq.size() != 0));
    if (mq.size() != 0) chk("pe_data", {pe_head, pe_tail, pe_flit}, mq[0]);
    else                chk("pe_tags_empty", 66'({pe_head, pe_tail}), 66'd0);
    chk("buffer_on", 66'(buffer_on_out), 66'(m_bon));
    chk("pkt_count", 66'(pkt_count), 66'(m_pkt));
    chk("flit_count", 66'(flit_count), 66'(m_flit));
    chk("misroute", 66'(misroute_count), 66'(m_mis));
    chk("overflow", 66'(overflow_err), 66'(m_ovf));
  endtask

  task automatic cycle(input logic v, input logic [63:0] f, input logic r);
    bit pop, push, hd, tl;
    valid_in = v;
    flit_in  = f;
    pe_ready = r;
    pop  = (mq.size() > 0) && r;
    push = v && ((mq.size() < BS) || pop);
    if (pop) void'(mq.pop_front());
    if (push) begin
      hd = ((m_acc % FPP) == 0);
      tl = ((m_acc % FPP) == FPP - 1);
      mq.push_back({hd, tl, f});
      m_acc++;
      m_flit = m_flit + 16'd1;
      if (tl) m_pkt = m_pkt + 16'd1;
      if (hd && (f[63:62] != 2'b01 || f[61:60] != 2'b01) && m_mis != 8'hFF) m_mis = m_mis + 8'd1;
    end else if (v) begin
      m_ovf = 1'b1;
    end
    m_bon = (mq.size() <= BS - 2);
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    valid_in = 1'b0;
    pe_ready = 1'b0;
    flit_in  = '0;
    mq.delete();
    m_acc = 0; m_pkt = '0; m_flit = '0; m_mis = '0; m_ovf = 1'b0; m_bon = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check_outputs();
  endtask

  initial begin
    logic [63:0] f;
    logic        s, b_before;
    int          acc_before;

    // 1: reset, one well-addressed packet streamed straight through
    do_reset();
    cycle(1'b0, 64'd0, 1'b1);
    cycle(1'b1, {2'b01, 2'b01, 60'h0}, 1'b1);
    for (int i = 1; i < FPP; i++) cycle(1'b1, 64'h1000 + 64'(i), 1'b1);
    cycle(1'b0, 64'd0, 1'b1);
    chk("t1_pkt", 66'(pkt_count), 66'd1);

    // 2: misrouted head is counted but still delivered
    cycle(1'b1, {2'b10, 2'b01, 60'hABC}, 1'b1);
    for (int i = 1; i < FPP; i++) cycle(1'b1, 64'h2000 + 64'(i), 1'b1);
    cycle(1'b0, 64'd0, 1'b1);
    chk("t2_mis", 66'(misroute_count), 66'd1);

    // 3: sender reacting one cycle late to buffer_on fills the FIFO exactly
    s = 1'b1;
    acc_before = m_acc;
    for (int i = 0; i < 12; i++) begin
      b_before = buffer_on_out;
      cycle(s, 64'h3000 + 64'(i), 1'b0);
      s = b_before;
    end
    chk("t3_accepted", 66'(m_acc - acc_before), 66'(BS));
    chk("t3_no_ovf", 66'(overflow_err), 66'd0);

    // 4: forced write into a full FIFO is dropped and latched
    cycle(1'b1, 64'hDEAD_DEAD_DEAD_DEAD, 1'b0);
    cycle(1'b0, 64'd0, 1'b0);
    chk("t4_ovf_sticky", 66'(overflow_err), 66'd1);

    // 5: full FIFO with simultaneous push and pop, then drain
    cycle(1'b1, 64'h5555, 1'b1);
    for (int i = 0; i < BS + 1; i++) cycle(1'b0, 64'd0, 1'b1);

    // 6: reset mid-packet discards the partial packet
    cycle(1'b1, {2'b01, 2'b01, 60'h6}, 1'b0);
    cycle(1'b1, 64'h6001, 1'b0);
    do_reset();
    for (int i = 0; i < FPP; i++) cycle(1'b1, {2'b01, 2'b01, 60'h700 + 60'(i)}, 1'b1);
    cycle(1'b0, 64'd0, 1'b1);
    chk("t6_pkt", 66'(pkt_count), 66'd1);

    // randomized traffic with random backpressure
    for (int n = 0; n < 400; n++) begin
      f = {$urandom, $urandom};
      if ($urandom_range(0, 3) != 0) f[63:60] = 4'b0101;
      cycle(1'($urandom_range(0, 3) != 0), f, 1'($urandom_range(0, 2) != 0));
    end
    for (int i = 0; i < BS + 1; i++) cycle(1'b0, 64'd0, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
